// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO read arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Queue-id width; a single-bit minimum keeps degenerate widths legal.
    function automatic int qid_w(input int num_q);
        return (num_q > 1) ? $clog2(num_q) : 1;
    endfunction

    // Beat counter width: it only ever holds 0..MAX_BURST-1.
    function automatic int bcnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rtl/fifo_rd_arbiter_rr_pick.sv - combinational round-robin picker with wrap
module rr_pick #(
    parameter int NUM_Q = 4,
    parameter int QID_W = 2
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] start,
    output logic             found,
    output logic [QID_W-1:0] idx
);

    logic [QID_W:0] cand;

    // Search upward from start; the wrap is explicit so NUM_Q need not be a power of 2.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            cand = {1'b0, start} + (QID_W+1)'(k);
            if (cand >= (QID_W+1)'(NUM_Q)) begin
                cand = cand - (QID_W+1)'(NUM_Q);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand[QID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst read scheduler over NUM_Q FIFOs
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_Q     = 4,
    parameter int  DSIZE     = 8,
    parameter int  MAX_BURST = 4,
    localparam int QID_W     = qid_w(NUM_Q),
    localparam int BCNT_W    = bcnt_w(MAX_BURST)
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [NUM_Q-1:0]       q_enable,
    input  logic [NUM_Q-1:0]       rempty,
    input  logic [NUM_Q*DSIZE-1:0] rdata,
    output logic [NUM_Q-1:0]       rinc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DSIZE-1:0]       out_data,
    output logic [QID_W-1:0]       out_qid,
    output logic                   out_last
);

    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
    localparam logic [QID_W-1:0]  LAST_Q    = QID_W'(NUM_Q - 1);

    arb_state_e        state_q, state_d;
    logic [QID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [QID_W-1:0]  grant_q, grant_d;
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              out_valid_q, out_valid_d;
    logic [DSIZE-1:0]  out_data_q, out_data_d;
    logic [QID_W-1:0]  out_qid_q, out_qid_d;
    logic              out_last_q, out_last_d;

    logic              pick_found;
    logic [QID_W-1:0]  pick_idx;
    logic              grant_empty;
    logic [DSIZE-1:0]  grant_data;
    logic [QID_W-1:0]  next_ptr;
    logic              beat_last;
    logic              load;

    rr_pick #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_pick (
        .req   (q_enable & ~rempty),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted FIFO's empty flag and head word.
    always_comb begin
        grant_empty = 1'b1;
        grant_data  = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant_q == QID_W'(i)) begin
                grant_empty = rempty[i];
                grant_data  = rdata[i*DSIZE +: DSIZE];
            end
        end
    end

    assign next_ptr  = (grant_q == LAST_Q) ? '0 : grant_q + QID_W'(1);
    assign beat_last = (beat_cnt_q == LAST_BEAT);
    assign load      = (state_q == BURST) && !grant_empty && (!out_valid_q || out_ready);

    // Pop the granted FIFO exactly on the cycles a beat enters the output register.
    always_comb begin
        rinc = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (load && (grant_q == QID_W'(i))) begin
                rinc[i] = 1'b1;
            end
        end
    end

    // Grant/burst next-state: a burst ends after MAX_BURST beats or when its FIFO runs dry.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (load) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    if (beat_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end else if (grant_empty) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-entry output register: load a new beat or drain on acceptance.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_qid_d   = out_qid_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_qid_d   = grant_q;
            out_last_d  = beat_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output stage registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qid_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_qid_q   <= out_qid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_qid   = out_qid_q;
    assign out_last  = out_last_q;

endmodule
